ff_mode_bank: RTL and testbench
===============================

# ff_mode_bank

Parametrised bank of WIDTH flip-flops whose next-state function (D, T, JK or SR) is chosen by a registered mode. It is the general successor to single-bit flip-flop conversion cells, for use wherever a datapath needs a runtime-selectable storage behaviour. It adds a synchronous clear, a clock enable, sticky detection of the illegal SR input (S=R=1), and a saturating count of the cycles in which the bank changed state.

## Interface
- WIDTH, 8: number of flip-flop bits (≥1)
- RST_VAL, {WIDTH{1'b0}}: value of q after reset or synchronous clear
- CNT_W, 8: width of the change counter (≥1)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- en  in  1  clock enable for the q update
- clr  in  1  synchronous clear of q to RST_VAL
- mode_ld  in  1  load mode_in into the mode register
- mode_in  in  2  00=D, 01=T, 10=JK, 11=SR
- a  in  WIDTH  D / T / J / S input per bit
- b  in  WIDTH  K / R input per bit; ignored in D and T modes
- err_clr  in  1  clears sr_err and err_mask
- q  out  WIDTH  stored state
- q_bar  out  WIDTH  ~q, combinational
- mode  out  2  current registered mode
- sr_err  out  1  sticky flag: illegal SR input was seen
- err_mask  out  WIDTH  sticky per-bit OR of illegal SR bits
- chg_cnt  out  CNT_W  saturating count of cycles in which q changed

## Operation
- Reset values (asynchronous, on rst high):
  - q=RST_VAL, so q_bar=~RST_VAL
  - mode=00 (D)
  - sr_err=0, err_mask=0, chg_cnt=0
- Next-state function per bit i, evaluated with the current registered mode:
  - D: a[i]
  - T: q[i]^a[i]
  - JK: (a[i]&~q[i]) | (~b[i]&q[i])
  - SR: a[i] | (~b[i]&q[i]) when not (a[i]&b[i]); hold q[i] when a[i]&b[i]
- Synchronous priority for q, highest first:
  1. clr: q←RST_VAL
  2. mode_ld: q holds, mode←mode_in
  3. en: q←next-state
  4. otherwise q holds
- clr and mode_ld may be asserted together: q is cleared and the mode is also loaded.
- Error capture:
  - Illegal set = {mode==SR & en & ~clr & ~mode_ld} & a & b.
  - Each edge: err_mask←err_mask | illegal; sr_err←sr_err | (|illegal).
  - err_clr wins over a simultaneous new error: both registers are cleared, and the new error is not captured.
- Change counter:
  - Increments on an edge where the new q differs from the old q; this includes a change caused by clr.
  - Saturates at 2^CNT_W−1.
  - Cleared only by rst.

## Timing
- All outputs are registered, except q_bar, which follows q combinationally.
- Latency: inputs sampled at edge n appear on q at edge n (visible in cycle n+1). The update takes one cycle.
- A mode loaded at edge n governs the next-state evaluation from edge n+1. No q update happens at edge n.
- sr_err, err_mask and chg_cnt update on the same edge as the q update they describe.
- Reset asserted mid-operation forces all reset values immediately, regardless of clk. On deassertion, the first edge with rst low behaves normally.

## Structure
- Package ff_mode_pkg holds:
  - the enumerated mode type (MODE_D, MODE_T, MODE_JK, MODE_SR)
  - the 2-bit encoding constants above
- Sub-module ff_next_state: purely combinational, per-bit next-state and illegal-flag function, parameterised on WIDTH, instantiated once.
- ff_mode_bank holds:
  - the mode register
  - the q register
  - the error registers
  - the saturating counter

## Test plan
- Reset and D mode (WIDTH=8, RST_VAL=0):
  - Stimulus: rst pulse, then en=1, a=8'hA5.
  - Response: after reset q=00, q_bar=FF, mode=0, chg_cnt=0. One edge later q=A5, chg_cnt=1.
- T mode:
  - Stimulus: mode_ld with mode_in=01 while q=A5, with en=1 and a=FF in the same cycle.
  - Response: q stays A5 on the load edge. With a=FF held, the next two edges give q=5A, then A5. chg_cnt increases by 2.
- JK mode:
  - Stimulus: mode=10, q=0F, a=F0, b=3C, en=1.
  - Response: q=F3 (00 hold, 01 reset, 10 set, 11 toggle per bit). en=0 with the same inputs leaves q unchanged.
- SR mode, illegal input:
  - Stimulus: mode=11, q=00, a=81, b=01.
  - Response: q=80, sr_err=1, err_mask=01. Later legal cycles keep sr_err=1.
  - Stimulus: err_clr together with a new illegal input a=b=02.
  - Response: sr_err=0, err_mask=00.
- clr priority and mid-operation reset:
  - Stimulus: clr=1 with mode_ld=1 and en=1.
  - Response: q=RST_VAL and the mode is loaded.
  - Stimulus: rst asserted between edges.
  - Response: q, mode and the counters clear immediately.
- Counter saturation (CNT_W=2):
  - Stimulus: T mode with a=01, 5 enabled edges.
  - Response: chg_cnt=3 and holds at 3.

Source files
------------

// File: rtl/ff_mode_pkg.sv
// Mode encodings and enumerated type for the selectable flip-flop bank.
// Pure definitions: no logic, no latency, no flow control.
package ff_mode_pkg;

    localparam logic [1:0] ENC_D  = 2'b00;
    localparam logic [1:0] ENC_T  = 2'b01;
    localparam logic [1:0] ENC_JK = 2'b10;
    localparam logic [1:0] ENC_SR = 2'b11;

    typedef enum logic [1:0] {
        MODE_D  = ENC_D,
        MODE_T  = ENC_T,
        MODE_JK = ENC_JK,
        MODE_SR = ENC_SR
    } mode_t;

endpackage

// File: rtl/ff_mode_bank_if.sv
// Control, data and status bundle of the flip-flop bank.
// Plain level signals; the bank accepts inputs every cycle and never stalls.
interface ff_mode_bank_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             en;
    logic             clr;
    logic             mode_ld;
    logic [1:0]       mode_in;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             err_clr;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_bar;
    logic [1:0]       mode;
    logic             sr_err;
    logic [WIDTH-1:0] err_mask;
    logic [CNT_W-1:0] chg_cnt;

    modport master (
        output en, clr, mode_ld, mode_in, a, b, err_clr,
        input  q, q_bar, mode, sr_err, err_mask, chg_cnt
    );

    modport slave (
        input  en, clr, mode_ld, mode_in, a, b, err_clr,
        output q, q_bar, mode, sr_err, err_mask, chg_cnt
    );

endinterface

// File: rtl/ff_next_state.sv
// Combinational per-bit next state and illegal-SR flag for the selected mode.
// Zero latency; no flow control.
module ff_next_state
    import ff_mode_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  mode_t            mode,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] nxt,
    output logic [WIDTH-1:0] illegal
);

    always_comb begin
        nxt     = q;
        illegal = '0;
        case (mode)
            MODE_D:  nxt = a;
            MODE_T:  nxt = q ^ a;
            MODE_JK: nxt = (a & ~q) | (~b & q);
            MODE_SR: begin
                // S=R=1 bits hold rather than taking the set-dominant value
                illegal = a & b;
                nxt     = ((a | (~b & q)) & ~illegal) | (q & illegal);
            end
            default: nxt = q;
        endcase
    end

endmodule

// File: rtl/ff_mode_bank.sv
// WIDTH-bit flip-flop bank with runtime D/T/JK/SR mode, sticky SR error, change counter.
// One-cycle update latency; no backpressure, inputs are sampled every edge.
module ff_mode_bank
    import ff_mode_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
    parameter int               CNT_W   = 8
) (
    input logic          clk,
    input logic          rst,
    ff_mode_bank_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    mode_t            mode_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] illegal_raw;
    logic [WIDTH-1:0] illegal;
    logic             upd;
    logic             sr_err_r;
    logic [WIDTH-1:0] err_mask_r;
    logic [CNT_W-1:0] chg_cnt_r;

    ff_next_state #(.WIDTH(WIDTH)) u_next (
        .mode    (mode_r),
        .q       (q_r),
        .a       (bus.a),
        .b       (bus.b),
        .nxt     (nxt),
        .illegal (illegal_raw)
    );

    // A mode load freezes q for that edge; clr still overrides it.
    assign upd     = bus.en & ~bus.clr & ~bus.mode_ld;
    assign illegal = upd ? illegal_raw : '0;

    always_comb begin
        q_d = q_r;
        if (bus.clr)
            q_d = RST_VAL;
        else if (upd)
            q_d = nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r    <= RST_VAL;
            mode_r <= MODE_D;
        end else begin
            q_r <= q_d;
            if (bus.mode_ld)
                mode_r <= mode_t'(bus.mode_in);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_err_r   <= 1'b0;
            err_mask_r <= '0;
        end else if (bus.err_clr) begin
            sr_err_r   <= 1'b0;
            err_mask_r <= '0;
        end else begin
            sr_err_r   <= sr_err_r | (|illegal);
            err_mask_r <= err_mask_r | illegal;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            chg_cnt_r <= '0;
        else if ((q_d != q_r) && (chg_cnt_r != CNT_MAX))
            chg_cnt_r <= chg_cnt_r + CNT_ONE;
    end

    assign bus.q        = q_r;
    assign bus.q_bar    = ~q_r;
    assign bus.mode     = mode_r;
    assign bus.sr_err   = sr_err_r;
    assign bus.err_mask = err_mask_r;
    assign bus.chg_cnt  = chg_cnt_r;

endmodule

// File: tb/tb_ff_mode_bank.sv
// Directed-vector bench for ff_mode_bank: an 8-bit counter instance and a 2-bit-counter instance.
module tb_ff_mode_bank;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int vec_cnt  = 0;
    int miscmp   = 0;

    ff_mode_bank_if #(.WIDTH(8), .CNT_W(8)) bus0 ();
    ff_mode_bank_if #(.WIDTH(8), .CNT_W(2)) bus1 ();

    ff_mode_bank #(.WIDTH(8), .RST_VAL(8'h00), .CNT_W(8)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    ff_mode_bank #(.WIDTH(8), .RST_VAL(8'h00), .CNT_W(2)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscmp++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus0.en = 0; bus0.clr = 0; bus0.mode_ld = 0; bus0.mode_in = 2'b00;
        bus0.a = 8'h00; bus0.b = 8'h00; bus0.err_clr = 0;
        bus1.en = 0; bus1.clr = 0; bus1.mode_ld = 0; bus1.mode_in = 2'b00;
        bus1.a = 8'h00; bus1.b = 8'h00; bus1.err_clr = 0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_q",     bus0.q,        8'h00);
        chk("rst_qbar",  bus0.q_bar,    8'hFF);
        chk("rst_mode",  bus0.mode,     2'b00);
        chk("rst_cnt",   bus0.chg_cnt,  8'd0);
        chk("rst_err",   bus0.sr_err,   1'b0);
        chk("rst_mask",  bus0.err_mask, 8'h00);

        // D mode
        bus0.en = 1; bus0.a = 8'hA5;
        tick();
        chk("d_q",    bus0.q,       8'hA5);
        chk("d_qbar", bus0.q_bar,   8'h5A);
        chk("d_cnt",  bus0.chg_cnt, 8'd1);

        // load T while en=1, a=FF: q must hold on the load edge
        bus0.mode_ld = 1; bus0.mode_in = 2'b01; bus0.a = 8'hFF;
        tick();
        chk("tld_q",    bus0.q,       8'hA5);
        chk("tld_mode", bus0.mode,    2'b01);
        chk("tld_cnt",  bus0.chg_cnt, 8'd1);
        bus0.mode_ld = 0;
        tick();
        chk("t1_q", bus0.q, 8'h5A);
        tick();
        chk("t2_q",   bus0.q,       8'hA5);
        chk("t2_cnt", bus0.chg_cnt, 8'd3);

        // back to D to preload 0F, then JK
        bus0.mode_ld = 1; bus0.mode_in = 2'b00;
        tick();
        bus0.mode_ld = 0; bus0.a = 8'h0F;
        tick();
        chk("pre_jk_q", bus0.q, 8'h0F);
        bus0.mode_ld = 1; bus0.mode_in = 2'b10;
        tick();
        chk("jkld_q", bus0.q, 8'h0F);
        bus0.mode_ld = 0; bus0.a = 8'hF0; bus0.b = 8'h3C;
        tick();
        chk("jk_q",   bus0.q,       8'hF3);
        chk("jk_cnt", bus0.chg_cnt, 8'd5);
        bus0.en = 0;
        tick();
        chk("jk_hold_q",   bus0.q,       8'hF3);
        chk("jk_hold_cnt", bus0.chg_cnt, 8'd5);

        // clr to 00 counts as a change, then SR
        bus0.clr = 1;
        tick();
        chk("clr_q",   bus0.q,       8'h00);
        chk("clr_cnt", bus0.chg_cnt, 8'd6);
        bus0.clr = 0; bus0.mode_ld = 1; bus0.mode_in = 2'b11;
        tick();
        bus0.mode_ld = 0; bus0.en = 1; bus0.a = 8'h81; bus0.b = 8'h01;
        tick();
        chk("sr_q",    bus0.q,        8'h80);
        chk("sr_err",  bus0.sr_err,   1'b1);
        chk("sr_mask", bus0.err_mask, 8'h01);
        chk("sr_cnt",  bus0.chg_cnt,  8'd7);
        bus0.a = 8'h00; bus0.b = 8'h00;
        tick();
        chk("sr_legal_q",   bus0.q,        8'h80);
        chk("sr_sticky",    bus0.sr_err,   1'b1);
        chk("sr_mask_keep", bus0.err_mask, 8'h01);

        // err_clr beats a new illegal input
        bus0.err_clr = 1; bus0.a = 8'h02; bus0.b = 8'h02;
        tick();
        chk("eclr_err",  bus0.sr_err,   1'b0);
        chk("eclr_mask", bus0.err_mask, 8'h00);
        chk("eclr_q",    bus0.q,        8'h80);
        bus0.err_clr = 0;

        // illegal bits with en=0 are not captured
        bus0.en = 0; bus0.a = 8'h04; bus0.b = 8'h04;
        tick();
        chk("noen_err", bus0.sr_err, 1'b0);

        // clr + mode_ld + en with illegal inputs
        bus0.clr = 1; bus0.mode_ld = 1; bus0.mode_in = 2'b01; bus0.en = 1;
        bus0.a = 8'hFF; bus0.b = 8'hFF;
        tick();
        chk("prio_q",    bus0.q,       8'h00);
        chk("prio_mode", bus0.mode,    2'b01);
        chk("prio_err",  bus0.sr_err,  1'b0);
        chk("prio_cnt",  bus0.chg_cnt, 8'd8);
        bus0.clr = 0; bus0.mode_ld = 0; bus0.b = 8'h00;
        tick();
        chk("pre_rst_q",   bus0.q,       8'hFF);
        chk("pre_rst_cnt", bus0.chg_cnt, 8'd9);

        // asynchronous reset between edges
        bus0.en = 0;
        #2 rst = 1'b1;
        #1;
        chk("arst_q",    bus0.q,       8'h00);
        chk("arst_qbar", bus0.q_bar,   8'hFF);
        chk("arst_mode", bus0.mode,    2'b00);
        chk("arst_cnt",  bus0.chg_cnt, 8'd0);
        #1 rst = 1'b0;
        bus0.en = 1; bus0.a = 8'h3C;
        tick();
        chk("post_rst_q",   bus0.q,       8'h3C);
        chk("post_rst_cnt", bus0.chg_cnt, 8'd1);

        // 2-bit counter saturation on the second instance
        bus1.mode_ld = 1; bus1.mode_in = 2'b01;
        tick();
        bus1.mode_ld = 0; bus1.en = 1; bus1.a = 8'h01;
        tick(); chk("sat_cnt1", bus1.chg_cnt, 2'd1);
        tick(); chk("sat_cnt2", bus1.chg_cnt, 2'd2);
        tick(); chk("sat_cnt3", bus1.chg_cnt, 2'd3);
        tick(); chk("sat_cnt4", bus1.chg_cnt, 2'd3);
        tick(); chk("sat_cnt5", bus1.chg_cnt, 2'd3);
        chk("sat_q", bus1.q, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule
